// File: rtl/enoc_link_bank.sv
// Bank of independent credit-flow-controlled pipelined links for ENoC router-to-router wiring.
// Each channel: STAGES-deep forward pipe, FWFT receive FIFO, STAGES-deep credit return pipe.
module enoc_link_bank #(
    parameter int CHANNELS   = 5,
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 2*STAGES+2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  i_data,
    input  logic [CHANNELS-1:0]                  i_data_val,
    output logic [CHANNELS-1:0]                  o_en,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  o_data,
    output logic [CHANNELS-1:0]                  o_data_val,
    input  logic [CHANNELS-1:0]                  i_en,
    output logic [CHANNELS-1:0]                  o_busy,
    output logic [CHANNELS-1:0]                  o_err
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH-1);

    // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CW-1:0]         credits_q, credits_d;
        logic                  en_q, en_d;
        logic [STAGES-1:0]     fwd_vld_q, fwd_vld_d;
        logic [DATA_WIDTH-1:0] fwd_data_q [STAGES];
        logic [DATA_WIDTH-1:0] fwd_data_d [STAGES];
        logic [STAGES-1:0]     ret_q, ret_d;
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         count_q, count_d;
        logic                  err_q, err_d;
        logic                  push_up, credit_ret, fifo_push, fifo_pop, fifo_wr;

        always_comb begin
            push_up    = i_data_val[c] & en_q;
            credit_ret = ret_q[STAGES-1];
            fifo_push  = fwd_vld_q[STAGES-1];
            fifo_pop   = (count_q != '0) & i_en[c];
            // A full FIFO still accepts a write when the head leaves in the same cycle.
            fifo_wr    = fifo_push & ((count_q != CRED_MAX) | fifo_pop);

            credits_d  = credits_q - CW'(push_up) + CW'(credit_ret);
            en_d       = (credits_d != '0);

            fwd_vld_d[0]  = push_up;
            fwd_data_d[0] = i_data[c];
            ret_d[0]      = fifo_pop;
            for (int k = 1; k < STAGES; k++) begin
                fwd_vld_d[k]  = fwd_vld_q[k-1];
                fwd_data_d[k] = fwd_data_q[k-1];
                ret_d[k]      = ret_q[k-1];
            end

            wr_ptr_d = fifo_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            count_d  = count_q + CW'(fifo_wr) - CW'(fifo_pop);
            err_d    = err_q | (fifo_push & ~fifo_wr);
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                credits_q <= CRED_MAX;
                en_q      <= 1'b0;
                fwd_vld_q <= '0;
                ret_q     <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                err_q     <= 1'b0;
            end else begin
                credits_q <= credits_d;
                en_q      <= en_d;
                fwd_vld_q <= fwd_vld_d;
                ret_q     <= ret_d;
                wr_ptr_q  <= wr_ptr_d;
                rd_ptr_q  <= rd_ptr_d;
                count_q   <= count_d;
                err_q     <= err_d;
            end
        end

        // Data storage carries no reset; the valid bits and count qualify it.
        always_ff @(posedge clk) begin
            fwd_data_q <= fwd_data_d;
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= fwd_data_q[STAGES-1];
            end
        end

        assign o_en[c]       = en_q;
        assign o_data[c]     = mem_q[rd_ptr_q];
        assign o_data_val[c] = (count_q != '0);
        assign o_busy[c]     = (credits_q != CRED_MAX);
        assign o_err[c]      = err_q;
    end

endmodule
